// File: rtl/vga_renderer_pkg.sv
// Shared codes, colours and default 640x480@60 timing for the VGA render path.
package vga_renderer_pkg;

    typedef enum logic [3:0] {
        CAT_NONE   = 4'd0,
        CAT_WALL   = 4'd1,
        CAT_TANK   = 4'd2,
        CAT_BULLET = 4'd3
    } category_e;

    typedef enum logic [2:0] {
        DIR_LEFT  = 3'd0,
        DIR_RIGHT = 3'd1,
        DIR_UP    = 3'd2,
        DIR_DOWN  = 3'd3
    } direction_e;

    localparam logic [11:0] BLACK         = 12'h000;
    localparam logic [11:0] WALL_GREY     = 12'h888;
    localparam logic [11:0] BULLET_YELLOW = 12'hFF0;
    localparam logic [11:0] DEAD_RED      = 12'h400;
    localparam logic [11:0] TRANSPARENT   = 12'hF0F;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FP      = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BP      = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FP      = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BP      = 33;

    localparam int SPRITE       = 30;
    localparam int SPRITE_WORDS = SPRITE * SPRITE;

endpackage

// File: rtl/vga_renderer_if.sv
// Game-loop render bus: the renderer publishes the pixel position, the game loop answers with its contents.
interface vga_renderer_if;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic [3:0] category;
    logic [9:0] addr;
    logic [2:0] tank_direct;
    logic       alive;

    modport master (
        output pixel_x, pixel_y,
        input  category, addr, tank_direct, alive
    );

    modport slave (
        input  pixel_x, pixel_y,
        output category, addr, tank_direct, alive
    );
endinterface

// File: rtl/vga_renderer_timing.sv
// Pixel-clock divider and h/v raster counters with sync/visible decode of the current position.
module vga_timing
    import vga_renderer_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP
) (
    input  logic       clk_100mhz,
    input  logic       rst,
    output logic       sample_en,
    output logic       pixel_tick,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output logic       vis,
    output logic       hs_n,
    output logic       vs_n
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    logic [1:0] phase;

    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) begin
            phase <= 2'd0;
            h_cnt <= 10'd0;
            v_cnt <= 10'd0;
        end else begin
            phase <= phase + 2'd1;
            if (pixel_tick) begin
                if (h_cnt == 10'(H_TOTAL - 1)) begin
                    h_cnt <= 10'd0;
                    if (v_cnt == 10'(V_TOTAL - 1))
                        v_cnt <= 10'd0;
                    else
                        v_cnt <= v_cnt + 10'd1;
                end else begin
                    h_cnt <= h_cnt + 10'd1;
                end
            end
        end
    end

    // Game-loop answers settle during phase 1, so that edge is the sampling point.
    assign sample_en  = (phase == 2'd1);
    assign pixel_tick = (phase == 2'd3);

    assign vis  = (h_cnt < 10'(H_VISIBLE)) && (v_cnt < 10'(V_VISIBLE));
    assign hs_n = !((h_cnt >= 10'(H_VISIBLE + H_FP)) &&
                    (h_cnt <  10'(H_VISIBLE + H_FP + H_SYNC)));
    assign vs_n = !((v_cnt >= 10'(V_VISIBLE + V_FP)) &&
                    (v_cnt <  10'(V_VISIBLE + V_FP + V_SYNC)));

endmodule

// File: rtl/vga_renderer.sv
// VGA pixel consumer: samples the game loop per pixel, rotates the tank sprite lookup and
// emits RGB with sync through one identical 1-pixel pipeline.
module vga_renderer
    import vga_renderer_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP
) (
    input  logic                 clk_100mhz,
    input  logic                 rst,
    vga_renderer_if.master       gl,
    input  logic [11:0]          rom_data,
    output logic [9:0]           rom_addr,
    output logic [3:0]           vga_r,
    output logic [3:0]           vga_g,
    output logic [3:0]           vga_b,
    output logic                 hsync,
    output logic                 vsync
);

    logic       sample_en;
    logic       pixel_tick;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       vis;
    logic       hs_n;
    logic       vs_n;

    vga_timing #(
        .H_VISIBLE (H_VISIBLE),
        .H_FP      (H_FP),
        .H_SYNC    (H_SYNC),
        .H_BP      (H_BP),
        .V_VISIBLE (V_VISIBLE),
        .V_FP      (V_FP),
        .V_SYNC    (V_SYNC),
        .V_BP      (V_BP)
    ) u_timing (
        .clk_100mhz (clk_100mhz),
        .rst        (rst),
        .sample_en  (sample_en),
        .pixel_tick (pixel_tick),
        .h_cnt      (h_cnt),
        .v_cnt      (v_cnt),
        .vis        (vis),
        .hs_n       (hs_n),
        .vs_n       (vs_n)
    );

    assign gl.pixel_x = h_cnt;
    assign gl.pixel_y = v_cnt;

    // Index n = row*30+col; row via reciprocal multiply (exact for n < 900), out-of-range maps to 0.
    function automatic logic [9:0] sprite_rom_addr(input logic [9:0] idx, input logic [2:0] dir);
        logic [9:0]  n;
        logic [20:0] prod;
        logic [4:0]  r;
        logic [4:0]  c;
        logic [4:0]  sr;
        logic [4:0]  sc;
        n    = (idx == 10'd0 || idx > 10'(SPRITE_WORDS)) ? 10'd0 : idx - 10'd1;
        prod = 21'(n) * 21'd1093;
        r    = 5'(prod >> 15);
        c    = 5'(n - 10'(r) * 10'(SPRITE));
        case (dir)
            DIR_LEFT: begin
                sr = r;
                sc = 5'(SPRITE - 1) - c;
            end
            DIR_UP: begin
                sr = c;
                sc = 5'(SPRITE - 1) - r;
            end
            DIR_DOWN: begin
                sr = c;
                sc = r;
            end
            default: begin
                sr = r;
                sc = c;
            end
        endcase
        return 10'(sr) * 10'(SPRITE) + 10'(sc);
    endfunction

    function automatic logic [11:0] pixel_colour(input logic vld, input logic [3:0] cat,
                                                 input logic alv, input logic [11:0] rom);
        logic [11:0] bg;
        logic [11:0] col;
        bg = alv ? BLACK : DEAD_RED;
        case (cat)
            CAT_NONE:   col = bg;
            CAT_WALL:   col = WALL_GREY;
            CAT_TANK:   col = (rom == TRANSPARENT) ? bg : rom;
            CAT_BULLET: col = BULLET_YELLOW;
            default:    col = BLACK;
        endcase
        return vld ? col : BLACK;
    endfunction

    logic        vld_p1;
    logic [3:0]  cat_p1;
    logic        alive_p1;
    logic        hs_p1;
    logic        vs_p1;
    logic [11:0] rgb_p2;
    logic        hs_p2;
    logic        vs_p2;

    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            cat_p1   <= 4'd0;
            alive_p1 <= 1'b0;
            hs_p1    <= 1'b1;
            vs_p1    <= 1'b1;
            rom_addr <= 10'd0;
            rgb_p2   <= BLACK;
            hs_p2    <= 1'b1;
            vs_p2    <= 1'b1;
        end else begin
            // Stage p1: capture game-loop answer and launch the rotated ROM read.
            if (sample_en) begin
                vld_p1   <= vis;
                cat_p1   <= gl.category;
                alive_p1 <= gl.alive;
                hs_p1    <= hs_n;
                vs_p1    <= vs_n;
                rom_addr <= sprite_rom_addr(gl.addr, gl.tank_direct);
            end
            // Stage p2: colour and sync leave together on the pixel tick.
            if (pixel_tick) begin
                rgb_p2 <= pixel_colour(vld_p1, cat_p1, alive_p1, rom_data);
                hs_p2  <= hs_p1;
                vs_p2  <= vs_p1;
            end
        end
    end

    assign vga_r = rgb_p2[11:8];
    assign vga_g = rgb_p2[7:4];
    assign vga_b = rgb_p2[3:0];
    assign hsync = hs_p2;
    assign vsync = vs_p2;

endmodule

// File: tb/tb_vga_renderer.sv
// Randomized bench for vga_renderer against a pixel-index reference model (shortened vertical timing).
module tb_vga_renderer;

    localparam int H_TOT  = 800;
    localparam int V_VIS  = 8;
    localparam int V_FP   = 2;
    localparam int V_SYNC = 2;
    localparam int V_BP   = 3;
    localparam int V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;

    logic        clk_100mhz = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] rom_data;
    logic [9:0]  rom_addr;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;
    logic        hsync;
    logic        vsync;
    logic [11:0] rom_mem [900];

    vga_renderer_if gl();

    vga_renderer #(
        .V_VISIBLE (V_VIS),
        .V_FP      (V_FP),
        .V_SYNC    (V_SYNC),
        .V_BP      (V_BP)
    ) dut (
        .clk_100mhz (clk_100mhz),
        .rst        (rst),
        .gl         (gl),
        .rom_data   (rom_data),
        .rom_addr   (rom_addr),
        .vga_r      (vga_r),
        .vga_g      (vga_g),
        .vga_b      (vga_b),
        .hsync      (hsync),
        .vsync      (vsync)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    always @(posedge clk_100mhz)
        rom_data <= (rom_addr < 10'd900) ? rom_mem[rom_addr] : 12'h000;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_rom_addr(input int a, input int d);
        int n;
        int r;
        int c;
        n = (a >= 1 && a <= 900) ? a - 1 : 0;
        r = n / 30;
        c = n % 30;
        case (d)
            0:       return r * 30 + (29 - c);
            2:       return c * 30 + (29 - r);
            3:       return c * 30 + r;
            default: return r * 30 + c;
        endcase
    endfunction

    function automatic logic [11:0] ref_colour(input int h, input int v, input int cat,
                                               input bit alv, input logic [11:0] rom);
        logic [11:0] bg;
        bg = alv ? 12'h000 : 12'h400;
        if (!(h < 640 && v < V_VIS)) return 12'h000;
        case (cat)
            0:       return bg;
            1:       return 12'h888;
            2:       return (rom == 12'hF0F) ? bg : rom;
            3:       return 12'hFF0;
            default: return 12'h000;
        endcase
    endfunction

    int          p;
    bit          have_prev;
    logic [11:0] prev_rgb;
    logic        prev_hs;
    logic        prev_vs;
    int          first_hs_low;
    int          hs_low_line0;
    int          vs_low_frame;

    // Entered at the negedge that opens pixel p; leaves at the negedge that opens pixel p+1.
    task automatic step_pixel(input int cat, input int a, input int d, input bit alv);
        int h;
        int v;
        int ra;
        h = p % H_TOT;
        v = (p / H_TOT) % V_TOT;
        check($sformatf("pixel_x p=%0d", p), 32'(gl.pixel_x), h);
        check($sformatf("pixel_y p=%0d", p), 32'(gl.pixel_y), v);
        if (have_prev) begin
            check($sformatf("rgb p=%0d", p - 1), 32'({vga_r, vga_g, vga_b}), 32'(prev_rgb));
            check($sformatf("hsync p=%0d", p - 1), 32'(hsync), 32'(prev_hs));
            check($sformatf("vsync p=%0d", p - 1), 32'(vsync), 32'(prev_vs));
            if (hsync == 1'b0) begin
                if (first_hs_low < 0) first_hs_low = p - 1;
                if (p - 1 < H_TOT) hs_low_line0++;
            end
            if (vsync == 1'b0 && p - 1 < V_TOT * H_TOT) vs_low_frame++;
        end else begin
            check("rgb_after_reset", 32'({vga_r, vga_g, vga_b}), 32'h000);
            check("hsync_after_reset", 32'(hsync), 32'h1);
            check("vsync_after_reset", 32'(vsync), 32'h1);
        end
        gl.category    = 4'(cat);
        gl.addr        = 10'(a);
        gl.tank_direct = 3'(d);
        gl.alive       = alv;
        ra       = ref_rom_addr(a, d);
        prev_rgb = ref_colour(h, v, cat, alv, rom_mem[ra]);
        prev_hs  = !(h >= 656 && h < 752);
        prev_vs  = !(v >= V_VIS + V_FP && v < V_VIS + V_FP + V_SYNC);
        have_prev = 1'b1;
        @(negedge clk_100mhz);
        @(negedge clk_100mhz);
        check($sformatf("rom_addr a=%0d d=%0d", a, d), 32'(rom_addr), ra);
        @(negedge clk_100mhz);
        @(negedge clk_100mhz);
        p++;
    endtask

    task automatic random_pixel();
        int cat;
        cat = ($urandom_range(0, 7) == 0) ? int'($urandom_range(4, 15)) : int'($urandom_range(0, 3));
        step_pixel(cat, int'($urandom_range(0, 1023)), int'($urandom_range(0, 7)),
                   $urandom_range(0, 3) != 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pixel_x"}, 32'(gl.pixel_x), 0);
        check({tag, "_pixel_y"}, 32'(gl.pixel_y), 0);
        check({tag, "_rom_addr"}, 32'(rom_addr), 0);
        check({tag, "_rgb"}, 32'({vga_r, vga_g, vga_b}), 0);
        check({tag, "_hsync"}, 32'(hsync), 1);
        check({tag, "_vsync"}, 32'(vsync), 1);
    endtask

    initial begin
        for (int i = 0; i < 900; i++)
            rom_mem[i] = (i % 7 == 3) ? 12'hF0F : 12'($urandom);
        rom_mem[0]  = 12'hF0F;
        rom_mem[29] = 12'h0A0;
        gl.category    = 4'd0;
        gl.addr        = 10'd0;
        gl.tank_direct = 3'd0;
        gl.alive       = 1'b1;

        rst = 1'b1;
        repeat (3) @(negedge clk_100mhz);
        check_reset_outputs("reset");
        rst = 1'b0;
        p = 0;
        have_prev = 1'b0;
        first_hs_low = -1;
        hs_low_line0 = 0;
        vs_low_frame = 0;

        // One full frame plus five lines and 300 pixels, landing on h=300, v=5.
        for (int k = 0; k < V_TOT * H_TOT + 5 * H_TOT + 300; k++) begin
            if (k < 3600)
                step_pixel(2, k / 4 + 1, k % 4, 1'($urandom));
            else if (k < 3608)
                step_pixel(2, (k % 2 == 1) ? 901 : 0, (k / 2) % 4, 1'b1);
            else if (k == 3608)
                step_pixel(2, 1, 1, 1'b0);
            else if (k == 3609)
                step_pixel(2, 30, 1, 1'b1);
            else if (k / H_TOT == 6)
                step_pixel(1, int'($urandom_range(0, 1023)), int'($urandom_range(0, 7)), 1'b1);
            else
                random_pixel();
        end
        check("first_hsync_low_pixel", first_hs_low, 656);
        check("hsync_low_pixels_line0", hs_low_line0, 96);
        check("vsync_low_pixels_frame", vs_low_frame, V_SYNC * H_TOT);

        check("pre_reset_pixel_x", 32'(gl.pixel_x), 300);
        check("pre_reset_pixel_y", 32'(gl.pixel_y), 5);
        rst = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        repeat (3) @(negedge clk_100mhz);
        check_reset_outputs("held_reset");
        rst = 1'b0;
        p = 0;
        have_prev = 1'b0;
        first_hs_low = -1;
        for (int k = 0; k < 700; k++)
            random_pixel();
        check("restart_first_hsync_low_pixel", first_hs_low, 656);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_renderer.md
Name: vga_renderer

Overview:
Pixel-consumer end of the game-loop render interface. It generates 640x480@60 VGA timing from clk_100mhz and drives pixel_x/pixel_y into the game loop. It samples the returned category, addr and tank_direct for each pixel, rotates the tank sprite lookup by direction, and outputs 12-bit RGB with matching hsync/vsync.

Parameters:
H_VISIBLE, 640, active pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels); line total = 800
V_VISIBLE, 480, active lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines); frame total = 525
SPRITE, 30, tank sprite edge in pixels (ROM holds SPRITE*SPRITE words, stored facing RIGHT)
TRANSPARENT, 12'hF0F, sprite colour key that is rendered as background

Ports:
clk_100mhz  in  1  system clock
rst  in  1  reset, asynchronous, active-high
category  in  4  game-loop class of current pixel: 0 NONE, 1 WALL, 2 TANK, 3 BULLET
addr  in  10  tank sprite index, row*30+col+1 (1..900), valid when category==TANK
tank_direct  in  3  direction of the tank under the pixel: 0 LEFT, 1 RIGHT, 2 UP, 3 DOWN
alive  in  1  player alive flag
rom_data  in  12  sprite ROM read data, synchronous ROM with 1-cycle latency
pixel_x  out  10  current horizontal count to game loop
pixel_y  out  10  current vertical count to game loop
rom_addr  out  10  sprite ROM address (0..899)
vga_r, vga_g, vga_b  out  4 each  colour
hsync, vsync  out  1 each  sync, active low

Behaviour:
- Reset: phase=0; h_cnt=v_cnt=0; pixel_x=pixel_y=0; rom_addr=0; rgb=0; hsync=vsync=1. Reset mid-frame aborts the frame. The first pixel tick after release advances from (0,0).
- phase is a 2-bit counter that increments every cycle; pixel_tick = (phase==3), giving 25 MHz.
- On pixel_tick: h_cnt wraps 799->0. On the h wrap, v_cnt increments and wraps 524->0. pixel_x=h_cnt and pixel_y=v_cnt are registered and change only on pixel_tick.
- The game loop registers its outputs one cycle after pixel_x/pixel_y change, so they are valid from phase 1.
- Edge ending phase 1: capture cat_q, dir_q, addr_q, and vis_q=(h<640 && v<480). Capture hs_q=~(656<=h<752) and vs_q=~(490<=v<492) for the same pixel.
- Phase 2: rom_addr (registered at the end of phase 1 from captured values) is presented to the ROM. rom_data is valid during phase 3.
- Sprite index decode: n = addr_q-1. If addr_q is 0 or >900, use n=0.
  - r = (n*1093)>>15 and c = n-30*r; exact for n in 0..899.
- Source coordinates (sr,sc) by dir_q:
  - RIGHT: (r,c)
  - LEFT: (r,29-c)
  - UP: (c,29-r)
  - DOWN: (c,r)
  - dir 4..7: treated as RIGHT
  - rom_addr = sr*30+sc.
- Edge ending phase 3 (pixel_tick) registers RGB and sync:
  - !vis_q: 12'h000
  - NONE: 12'h000 if alive, else 12'h400
  - WALL: 12'h888
  - TANK: rom_data, or background (as NONE) if rom_data==TRANSPARENT
  - BULLET: 12'hFF0
  - codes 4..15: 12'h000
  - hsync<=hs_q, vsync<=vs_q.
- Latency: RGB/sync for pixel (h,v) appear when the counters advance to the next pixel. This is a fixed 1-pixel (4-cycle) pipeline, identical for sync and colour, so the image is not shifted.
- alive is sampled at phase 1 with the other inputs.

Decomposition:
- Shared package: category codes (NONE/WALL/TANK/BULLET), direction codes (LEFT/RIGHT/UP/DOWN), colour constants (BLACK, WALL_GREY, BULLET_YELLOW, DEAD_RED), VGA timing defaults.
- Sub-module vga_timing: phase counter, h/v counters, pixel_tick, sync and visible decode.
- vga_renderer instantiates vga_timing and holds the sample/rotate/colour pipeline.

Test Plan:
- Release reset, run 1 frame -> hsync low for exactly 96 pixel ticks (384 cycles) per line starting at h=656. Line period 3200 cycles; vsync low for 2 lines starting at v=490; frame = 420000 pixel ticks.
- Hold category=1 constant -> rgb=12'h888 during visible and 12'h000 during blanking. Colour and sync edges align to the same pixel_tick.
- category=2, addr=1, each direction -> rom_addr = 0 (RIGHT), 29 (LEFT), 29 (UP), 0 (DOWN). With addr=900: 899, 870, 870, 899.
- Exhaustive addr 1..900 x 4 directions against a reference model -> rom_addr always matches and is never >899. addr=0 and addr=901 -> treated as n=0.
- category=2 with rom_data=12'hF0F and alive=0 -> rgb=12'h400. With rom_data=12'h0A0 -> rgb=12'h0A0.
- Assert rst at h=300,v=200 for 3 cycles -> outputs go to reset values immediately. After release the counters restart from (0,0) and the first hsync falls 656 pixel ticks later.
